alu_seq_mul: RTL and testbench

- Execute-stage ALU sitting directly downstream of the ALU controller.
- Consumes the 4-bit ALU operation code and the register or immediate operands.
- All operations except MUL complete combinationally in the same cycle.
- MUL runs as a 32-iteration shift-add sequence. During it, stall_o freezes the PC and pipeline until the product is ready.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_mul_seq_multiplier.sv | 97 +++++++++
 rtl/alu_seq_mul.sv | 97 +++++++++
 tb/tb_alu_seq_mul.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes and the
// multiplier sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRLV = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_JUMP = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/alu_seq_mul_seq_multiplier.sv
// Shift-add sequential multiplier: one partial-product step per clock,
// followed by a single DONE cycle presenting the low WIDTH bits of a*b.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] product_o,
  output logic             busy_o,
  output logic             done_o
);

  // Iteration index of the final shift-add step.
  localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath: latch operands on start, accumulate while busy.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = 5'd0;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // Pipeline advances here; a lingering MUL code must not restart.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign product_o = acc_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: rtl/alu_seq_mul.sv
// Execute-stage ALU: single-cycle ops are combinational, MUL is handed to
// the sequential multiplier and the pipeline is stalled until it finishes.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  input  logic [3:0]       ctrl_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             stall_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] comb_res_s;
  logic [WIDTH-1:0] product_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic             mul_req_s;
  logic             start_s;

  assign mul_req_s = valid_i && (ctrl_i == OP_MUL);
  // The multiplier only honours start in IDLE, so BUSY/DONE ignore inputs.
  assign start_s   = rst_i && mul_req_s;

  seq_multiplier #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_s),
    .a_i       (a_from_src1()),
    .b_i       (src2_i),
    .product_o (product_s),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s)
  );

  function automatic logic [WIDTH-1:0] a_from_src1();
    return src1_i;
  endfunction

  // Single-cycle operation mux; MUL and unknown codes yield zero here.
  always_comb begin
    comb_res_s = {WIDTH{1'b0}};
    case (ctrl_i)
      OP_AND:  comb_res_s = src1_i & src2_i;
      OP_OR:   comb_res_s = src1_i | src2_i;
      OP_ADD:  comb_res_s = src1_i + src2_i;
      OP_SUB:  comb_res_s = src1_i - src2_i;
      OP_SLT: begin
        if ($signed(src1_i) < $signed(src2_i)) begin
          comb_res_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          comb_res_s = {WIDTH{1'b0}};
        end
      end
      OP_SLL:  comb_res_s = src2_i << shamt_i;
      OP_SRLV: comb_res_s = src2_i >> src1_i[4:0];
      OP_LUI:  comb_res_s = src2_i << 5'd16;
      OP_JUMP: comb_res_s = src1_i;
      default: comb_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Result select and stall: reset forces the combinational path, busy
  // forces zero with stall, DONE presents the product for one cycle.
  always_comb begin
    result_o = comb_res_s;
    stall_o  = 1'b0;
    if (!rst_i) begin
      result_o = comb_res_s;
      stall_o  = 1'b0;
    end else if (mul_busy_s) begin
      result_o = {WIDTH{1'b0}};
      stall_o  = 1'b1;
    end else if (mul_done_s) begin
      result_o = product_s;
      stall_o  = 1'b0;
    end else begin
      result_o = comb_res_s;
      stall_o  = mul_req_s;
    end
  end

  assign zero_o = (result_o == {WIDTH{1'b0}});
  assign busy_o = mul_busy_s;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Self-checking bench for alu_seq_mul: a transaction-level reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_alu_seq_mul;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] src1_i, src2_i;
  logic [4:0]  shamt_i;
  logic [3:0]  ctrl_i;
  logic        valid_i;
  logic [31:0] result_o;
  logic        zero_o, stall_o, busy_o;

  int checks = 0;
  int errors = 0;

  alu_seq_mul #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .shamt_i (shamt_i),
    .ctrl_i  (ctrl_i),
    .valid_i (valid_i),
    .result_o(result_o),
    .zero_o  (zero_o),
    .stall_o (stall_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // phase: 0 = no multiply in flight, 1..32 = cycles after issue while
  // computing, 33 = the single cycle that presents the product.
  int          phase = 0;
  logic [31:0] prod  = 32'd0;
  bit          model_ok = 1'b0;

  function automatic logic [31:0] ref_op(logic [3:0] c, logic [31:0] a,
                                         logic [31:0] b, logic [4:0] sh);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return b << sh;
      4'd6:  return b >> a[4:0];
      4'd7:  return {b[15:0], 16'h0000};
      4'd10: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  always @(posedge clk_i) begin
    if (!rst_i) begin
      phase    <= 0;
      model_ok <= 1'b1;
    end else if (phase >= 1 && phase <= 32) begin
      phase <= phase + 1;
    end else if (phase == 33) begin
      phase <= 0;
    end else if (valid_i && ctrl_i == 4'd9) begin
      phase <= 1;
      prod  <= ref_mul(src1_i, src2_i);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    logic [31:0] e_res;
    logic        e_stall, e_busy;
    if (model_ok) begin
      e_busy = (phase >= 1 && phase <= 32);
      if (!rst_i) begin
        e_res = ref_op(ctrl_i, src1_i, src2_i, shamt_i); e_stall = 1'b0;
      end else if (e_busy) begin
        e_res = 32'd0; e_stall = 1'b1;
      end else if (phase == 33) begin
        e_res = prod; e_stall = 1'b0;
      end else begin
        e_res = ref_op(ctrl_i, src1_i, src2_i, shamt_i);
        e_stall = valid_i && ctrl_i == 4'd9;
      end
      checks++;
      if (result_o !== e_res || zero_o !== (e_res == 32'd0) ||
          stall_o !== e_stall || busy_o !== e_busy) begin
        errors++;
        $display("FAIL model t=%0t got res=%h z=%b st=%b bz=%b exp res=%h z=%b st=%b bz=%b",
                 $time, result_o, zero_o, stall_o, busy_o,
                 e_res, (e_res == 32'd0), e_stall, e_busy);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                       logic [4:0] sh, logic v);
    ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; valid_i = v;
  endtask

  task automatic next_cyc();
    @(posedge clk_i); #1;
  endtask

  // Single-cycle op: check combinational result in the current cycle.
  task automatic op_chk(string name, logic [3:0] c, logic [31:0] a,
                        logic [31:0] b, logic [4:0] sh, logic [31:0] exp_res);
    drive(c, a, b, sh, 1'b1);
    @(negedge clk_i);
    chk(name, result_o, exp_res);
    chk({name, "_zero"}, {31'd0, zero_o}, {31'd0, exp_res == 32'd0});
    chk({name, "_stall"}, {31'd0, stall_o}, 32'd0);
    next_cyc();
  endtask

  // Issue a MUL and follow it to its DONE cycle; chg >= 0 scrambles the
  // inputs in cycle N+chg to show the latched operands are used.
  task automatic mul_chk(string name, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp_res, int chg);
    int  stall_cnt = 0;
    int  busy_cnt  = 0;
    bit  seen      = 1'b0;
    drive(4'd9, a, b, 5'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == chg) drive(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b1);
      @(negedge clk_i);
      if (!stall_o) begin
        seen = 1'b1;
        break;
      end
      stall_cnt++;
      if (busy_o) busy_cnt++;
      next_cyc();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got no product exp product within 40 cycles", name);
    end else begin
      chk({name, "_res"}, result_o, exp_res);
      chk({name, "_stalls"}, stall_cnt, 32'd33);
      chk({name, "_busy"}, busy_cnt, 32'd32);
      chk({name, "_zero"}, {31'd0, zero_o}, {31'd0, exp_res == 32'd0});
    end
    next_cyc();
  endtask

  initial begin
    rst_i = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    next_cyc();
    next_cyc();
    @(negedge clk_i);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    // MUL during reset must not stall or start.
    drive(4'd9, 32'd3, 32'd3, 5'd0, 1'b1);
    @(negedge clk_i);
    chk("reset_mul_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_mul_res", result_o, 32'd0);
    next_cyc();
    rst_i = 1'b1;

    op_chk("add_wrap", 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
    op_chk("sub_zero", 4'd3, 32'd5, 32'd5, 5'd0, 32'd0);
    op_chk("slt_neg", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    op_chk("slt_pos", 4'd4, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
    op_chk("srlv", 4'd6, 32'd31, 32'h8000_0000, 5'd0, 32'd1);
    op_chk("lui", 4'd7, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000);
    op_chk("and", 4'd0, 32'hF0F0_FFFF, 32'h0FF0_00F0, 5'd0, 32'h00F0_00F0);
    op_chk("or", 4'd1, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F);
    op_chk("sll", 4'd5, 32'd0, 32'h0000_0003, 5'd4, 32'h0000_0030);
    op_chk("jump", 4'd10, 32'h0040_0100, 32'd7, 5'd0, 32'h0040_0100);
    op_chk("bad_op", 4'd15, 32'd1, 32'd2, 5'd0, 32'd0);

    // MUL with valid low: no start, no stall, result zero.
    drive(4'd9, 32'd7, 32'd6, 5'd0, 1'b0);
    @(negedge clk_i);
    chk("mul_novalid_stall", {31'd0, stall_o}, 32'd0);
    chk("mul_novalid_res", result_o, 32'd0);
    next_cyc();

    mul_chk("mul_7x6", 32'd7, 32'd6, 32'd42, -1);
    drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk_i);
    chk("after_done_busy", {31'd0, busy_o}, 32'd0);
    next_cyc();

    // Back-to-back: second MUL issued in the cycle right after DONE.
    mul_chk("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, -1);
    mul_chk("mul_wrap0", 32'h0001_0000, 32'h0001_0000, 32'd0, -1);
    mul_chk("mul_latch", 32'd3, 32'd4, 32'd12, 5);

    // Reset in cycle N+10 of a MUL discards it.
    drive(4'd9, 32'd3, 32'd5, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) next_cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    next_cyc();
    rst_i = 1'b1;
    drive(4'd2, 32'd2, 32'd2, 5'd0, 1'b1);
    @(negedge clk_i);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_stall2", {31'd0, stall_o}, 32'd0);
    chk("midrst_res", result_o, 32'd4);
    next_cyc();
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
